// File: rtl/ccip_rx_bookkeeper.sv
// RX bookkeeping for the CPU-NIC path: tracks each flow's consumed head pointer and writes it
// back to a per-flow host cache line over CCI-P c1, batched by entry count or by age.
package ccip_rx_bk_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

endpackage

module ccip_rx_bookkeeper
    import ccip_rx_bk_pkg::*;
#(
    parameter int LMAX_NUM_OF_FLOWS  = 1,
    parameter int LMAX_RX_QUEUE_SIZE = 1,
    parameter int LMAX_BK_BATCH      = 2,
    parameter int BK_TIMEOUT         = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [LMAX_NUM_OF_FLOWS-1:0]  number_of_flows,
    input  logic [LMAX_RX_QUEUE_SIZE-1:0] rx_queue_size,
    input  t_ccip_clAddr                  rx_bk_base_addr,
    input  logic                          ev_valid,
    input  logic [LMAX_NUM_OF_FLOWS-1:0]  ev_flow_id,
    input  logic [LMAX_RX_QUEUE_SIZE-1:0] ev_entry,
    input  logic                          sRx_c1TxAlmFull,
    output t_if_ccip_c1_Tx                sTx_c1,
    output logic                          error
);

    localparam int NF    = 2**LMAX_NUM_OF_FLOWS;
    localparam int FW    = LMAX_NUM_OF_FLOWS;
    localparam int QW    = LMAX_RX_QUEUE_SIZE;
    localparam int PW    = QW + 1;
    localparam int AW    = $clog2(BK_TIMEOUT + 1);
    localparam int BATCH = 2**LMAX_BK_BATCH;
    localparam logic [AW-1:0] AGE_MAX = AW'(BK_TIMEOUT);

    logic [QW-1:0]  r_head    [NF];
    logic [PW-1:0]  r_pending [NF];
    logic [AW-1:0]  r_age     [NF];
    logic [31:0]    r_seq     [NF];
    logic [FW-1:0]  r_rrPtr;
    t_if_ccip_c1_Tx r_tx;
    logic           r_error;

    logic           w_evAccept;
    logic           w_evBadFlow;
    logic [QW-1:0]  w_evNextHead;
    logic [NF-1:0]  w_evHit;
    logic [NF-1:0]  w_elig;
    logic [NF-1:0]  w_issueHit;
    logic           w_found;
    logic           w_issue;
    logic [FW-1:0]  w_winner;
    logic [FW-1:0]  w_rrNext;
    t_if_ccip_c1_Tx w_txNext;

    always_comb begin
        w_evBadFlow  = ev_valid && start && (ev_flow_id > number_of_flows);
        w_evAccept   = ev_valid && start && (ev_flow_id <= number_of_flows);
        w_evNextHead = (ev_entry == rx_queue_size) ? '0 : ev_entry + QW'(1);
        w_evHit      = '0;
        if (w_evAccept) begin
            w_evHit[ev_flow_id] = 1'b1;
        end
    end

    // A flow is ready once it has a full batch, or a partial batch that has aged out.
    always_comb begin
        w_elig = '0;
        for (int f = 0; f < NF; f++) begin
            if ((FW'(f) <= number_of_flows) &&
                ((int'(r_pending[f]) >= BATCH) ||
                 ((r_pending[f] != '0) && (r_age[f] == AGE_MAX)))) begin
                w_elig[f] = 1'b1;
            end
        end
    end

    // Round-robin: first eligible at or above the pointer, otherwise wrap to the lowest eligible.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int f = 0; f < NF; f++) begin
            if (!w_found && w_elig[f] && (FW'(f) >= r_rrPtr)) begin
                w_winner = FW'(f);
                w_found  = 1'b1;
            end
        end
        for (int f = 0; f < NF; f++) begin
            if (!w_found && w_elig[f]) begin
                w_winner = FW'(f);
                w_found  = 1'b1;
            end
        end
        w_issue    = start && !sRx_c1TxAlmFull && w_found;
        w_rrNext   = (w_winner == number_of_flows) ? '0 : w_winner + FW'(1);
        w_issueHit = '0;
        if (w_issue) begin
            w_issueHit[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_txNext = '0;
        if (w_issue) begin
            w_txNext.valid          = 1'b1;
            w_txNext.hdr.req_type   = eREQ_WRLINE_I;
            w_txNext.hdr.vc_sel     = eVC_VH0;
            w_txNext.hdr.cl_len     = eCL_LEN_1;
            w_txNext.hdr.sop        = 1'b1;
            w_txNext.hdr.address    = rx_bk_base_addr + t_ccip_clAddr'(w_winner);
            w_txNext.data[QW-1:0]   = r_head[w_winner];
            w_txNext.data[63:32]    = r_seq[w_winner];
        end
    end

    // An event landing on the flow being written is left out of this write and starts the next batch.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int f = 0; f < NF; f++) begin
                r_head[f]    <= '0;
                r_pending[f] <= '0;
                r_age[f]     <= '0;
                r_seq[f]     <= '0;
            end
            r_rrPtr <= '0;
            r_tx    <= '0;
            r_error <= 1'b0;
        end else begin
            r_tx <= w_txNext;
            if (w_evBadFlow || (w_evAccept && (ev_entry != r_head[ev_flow_id]))) begin
                r_error <= 1'b1;
            end
            if (w_issue) begin
                r_rrPtr <= w_rrNext;
            end
            for (int f = 0; f < NF; f++) begin
                if (w_evHit[f]) begin
                    r_head[f] <= w_evNextHead;
                end
                if (w_issueHit[f]) begin
                    r_pending[f] <= w_evHit[f] ? PW'(1) : '0;
                    r_age[f]     <= '0;
                    r_seq[f]     <= r_seq[f] + 32'd1;
                end else begin
                    if (w_evHit[f] && (r_pending[f] != '1)) begin
                        r_pending[f] <= r_pending[f] + PW'(1);
                    end
                    if ((r_pending[f] != '0) && (r_age[f] != AGE_MAX)) begin
                        r_age[f] <= r_age[f] + AW'(1);
                    end
                end
            end
        end
    end

    assign sTx_c1 = r_tx;
    assign error  = r_error;

endmodule

// File: tb/tb_ccip_rx_bookkeeper.sv
// Scoreboard bench for ccip_rx_bookkeeper: a per-flow reference model predicts every write
// and the error flag; a negedge monitor compares whatever the DUT presents.
module tb_ccip_rx_bookkeeper;
    import ccip_rx_bk_pkg::*;

    localparam int NFW   = 2;
    localparam int QW    = 3;
    localparam int LB    = 2;
    localparam int TO    = 30;
    localparam int NF    = 4;
    localparam int BATCH = 4;
    localparam int PMAX  = 15;
    localparam longint unsigned ADDR_MASK = (64'd1 << 42) - 64'd1;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [NFW-1:0]       number_of_flows;
    logic [QW-1:0]        rx_queue_size;
    t_ccip_clAddr         rx_bk_base_addr;
    logic                 ev_valid;
    logic [NFW-1:0]       ev_flow_id;
    logic [QW-1:0]        ev_entry;
    logic                 sRx_c1TxAlmFull;
    t_if_ccip_c1_Tx       sTx_c1;
    logic                 error;

    ccip_rx_bookkeeper #(
        .LMAX_NUM_OF_FLOWS (NFW),
        .LMAX_RX_QUEUE_SIZE(QW),
        .LMAX_BK_BATCH     (LB),
        .BK_TIMEOUT        (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .number_of_flows(number_of_flows),
        .rx_queue_size  (rx_queue_size),
        .rx_bk_base_addr(rx_bk_base_addr),
        .ev_valid       (ev_valid),
        .ev_flow_id     (ev_flow_id),
        .ev_entry       (ev_entry),
        .sRx_c1TxAlmFull(sRx_c1TxAlmFull),
        .sTx_c1         (sTx_c1),
        .error          (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int              due;
        longint unsigned addr;
        int              flow;
        int              head;
        longint unsigned seq;
    } expWrite_t;

    expWrite_t       expQ[$];
    int              total = 0;
    int              bad   = 0;
    int              cyc   = 0;
    int              mHead[NF];
    int              mPend[NF];
    int              mAge[NF];
    longint unsigned mSeq[NF];
    int              mRr;
    bit              mErr;

    int              writeCount = 0;
    int              lastHead;
    longint unsigned lastSeq;
    longint unsigned lastAddr;
    int              lastWriteCyc;
    int              lastEvCyc;
    int              writeOrder[$];
    int              writeCycs[$];

    task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit isElig(int f);
        return (mPend[f] >= BATCH) || ((mPend[f] > 0) && (mAge[f] == TO));
    endfunction

    // Reference model: one step per clock edge using the inputs sampled at that edge.
    always @(posedge clk) begin : model
        int        nf;
        int        fl;
        int        win;
        int        idx;
        bit        evOk;
        expWrite_t e;
        cyc++;
        if (reset) begin
            for (int f = 0; f < NF; f++) begin
                mHead[f] = 0;
                mPend[f] = 0;
                mAge[f]  = 0;
                mSeq[f]  = 0;
            end
            mRr  = 0;
            mErr = 0;
        end else begin
            nf  = int'(number_of_flows);
            fl  = int'(ev_flow_id);
            win = -1;
            if (start && !sRx_c1TxAlmFull) begin
                for (int k = 0; k <= nf; k++) begin
                    idx = (mRr + k) % (nf + 1);
                    if (win < 0 && isElig(idx)) win = idx;
                end
            end
            evOk = ev_valid && start && (fl <= nf);
            if (ev_valid && start && (fl > nf)) mErr = 1;
            if (win >= 0) begin
                e.due  = cyc;
                e.addr = (longint'(rx_bk_base_addr) + longint'(win)) & ADDR_MASK;
                e.flow = win;
                e.head = mHead[win];
                e.seq  = mSeq[win];
                expQ.push_back(e);
                mSeq[win] = (mSeq[win] + 1) & 64'hFFFF_FFFF;
                mRr = (win + 1) % (nf + 1);
            end
            for (int f = 0; f < NF; f++) begin
                if (f == win) begin
                    mPend[f] = (evOk && fl == f) ? 1 : 0;
                    mAge[f]  = 0;
                end else begin
                    if (mPend[f] != 0 && mAge[f] < TO) mAge[f]++;
                    if (evOk && fl == f && mPend[f] < PMAX) mPend[f]++;
                end
            end
            if (evOk) begin
                if (int'(ev_entry) != mHead[fl]) mErr = 1;
                mHead[fl] = (ev_entry == rx_queue_size) ? 0 : (int'(ev_entry) + 1) % (1 << QW);
            end
        end
    end

    always @(negedge clk) begin : monitor
        expWrite_t e;
        checkOutput("error_flag", error, mErr);
        if (sTx_c1.valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("write_cycle", cyc, e.due);
                checkOutput("write_addr", sTx_c1.hdr.address, e.addr);
                checkOutput("write_head", sTx_c1.data[QW-1:0], e.head);
                checkOutput("write_seq", sTx_c1.data[63:32], e.seq);
                checkOutput("write_hdr_fields",
                            {sTx_c1.hdr.req_type, sTx_c1.hdr.vc_sel, sTx_c1.hdr.cl_len, sTx_c1.hdr.sop},
                            9'b0000_10_00_1);
                checkOutput("write_data_zero",
                            {sTx_c1.data[511:64] != '0, sTx_c1.data[31:QW] != '0}, 0);
            end
            writeCount++;
            lastHead     = int'(sTx_c1.data[QW-1:0]);
            lastSeq      = sTx_c1.data[63:32];
            lastAddr     = sTx_c1.hdr.address;
            lastWriteCyc = cyc;
            writeOrder.push_back(int'(sTx_c1.hdr.address - rx_bk_base_addr));
            writeCycs.push_back(cyc);
        end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
            e = expQ.pop_front();
            checkOutput("missing_write", 0, 1);
        end
    end

    task automatic applyStimulus(input bit v, input int flow, input int entry);
        @(posedge clk);
        #1;
        ev_valid   = v;
        ev_flow_id = NFW'(flow);
        ev_entry   = QW'(entry);
        if (v) lastEvCyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        ev_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic randomStep();
        int fl;
        int en;
        @(posedge clk);
        #1;
        fl = $urandom_range(0, 3);
        if (fl <= int'(number_of_flows) && $urandom_range(0, 9) < 8) en = mHead[fl];
        else en = $urandom_range(0, int'(rx_queue_size));
        start           = ($urandom_range(0, 19) != 0);
        sRx_c1TxAlmFull = ($urandom_range(0, 4) == 0);
        ev_valid        = ($urandom_range(0, 2) != 0);
        ev_flow_id      = NFW'(fl);
        ev_entry        = QW'(en);
    endtask

    initial begin : stim
        int wc;
        int evCyc;
        reset           = 1'b1;
        start           = 1'b0;
        number_of_flows = '0;
        rx_queue_size   = 3'd7;
        rx_bk_base_addr = 42'h123_4567_8000;
        ev_valid        = 1'b0;
        ev_flow_id      = '0;
        ev_entry        = '0;
        sRx_c1TxAlmFull = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", sTx_c1.valid, 0);
        checkOutput("reset_error", error, 0);
        reset = 1'b0;
        start = 1'b1;

        $display("[TB] one flow, four back-to-back events");
        doReset();
        wc = writeCount;
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, i);
        evCyc = lastEvCyc;
        idle(8);
        checkOutput("s1_count", writeCount - wc, 1);
        checkOutput("s1_latency", lastWriteCyc - evCyc, 1);
        checkOutput("s1_head", lastHead, 4);
        checkOutput("s1_seq", lastSeq, 0);
        checkOutput("s1_addr", lastAddr, 42'h123_4567_8000);

        $display("[TB] head wrap through rx_queue_size");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, i);
        idle(4);
        applyStimulus(1, 0, 4);
        applyStimulus(1, 0, 5);
        idle(TO + 4);
        checkOutput("s2_head6", lastHead, 6);
        applyStimulus(1, 0, 6);
        applyStimulus(1, 0, 7);
        applyStimulus(1, 0, 0);
        idle(TO + 4);
        checkOutput("s2_head_wrapped", lastHead, 1);
        checkOutput("s2_seq", lastSeq, 2);
        checkOutput("s2_error", error, 0);

        $display("[TB] single event flushed by timeout");
        doReset();
        wc = writeCount;
        applyStimulus(1, 0, 0);
        evCyc = lastEvCyc;
        idle(TO + 6);
        checkOutput("s3_count", writeCount - wc, 1);
        checkOutput("s3_latency", lastWriteCyc - evCyc, TO + 1);
        checkOutput("s3_head", lastHead, 1);

        $display("[TB] four flows eligible together under backpressure");
        number_of_flows = 2'd3;
        doReset();
        sRx_c1TxAlmFull = 1'b1;
        wc = writeCount;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++) applyStimulus(1, f, i);
        idle(50);
        checkOutput("s4_blocked", writeCount - wc, 0);
        writeOrder.delete();
        writeCycs.delete();
        sRx_c1TxAlmFull = 1'b0;
        idle(8);
        checkOutput("s4_count", writeOrder.size(), 4);
        if (writeOrder.size() == 4) begin
            for (int i = 0; i < 4; i++) checkOutput("s4_order", writeOrder[i], i);
            checkOutput("s4_consecutive", writeCycs[3] - writeCycs[0], 3);
        end
        sRx_c1TxAlmFull = 1'b1;
        for (int i = 4; i < 8; i++) applyStimulus(1, 1, i);
        for (int i = 4; i < 8; i++) applyStimulus(1, 0, i);
        idle(2);
        writeOrder.delete();
        sRx_c1TxAlmFull = 1'b0;
        idle(6);
        checkOutput("s4_rr_count", writeOrder.size(), 2);
        if (writeOrder.size() == 2) begin
            checkOutput("s4_rr_first", writeOrder[0], 0);
            checkOutput("s4_rr_second", writeOrder[1], 1);
        end

        $display("[TB] out-of-order entry and out-of-range flow");
        number_of_flows = 2'd1;
        doReset();
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 5);
        idle(2);
        checkOutput("s6_error", error, 1);
        applyStimulus(1, 0, 6);
        idle(4);
        checkOutput("s6_head", lastHead, 7);
        wc = writeCount;
        applyStimulus(1, 3, 0);
        idle(TO + 5);
        checkOutput("s6_badflow_ignored", writeCount - wc, 0);
        checkOutput("s6_error_sticky", error, 1);

        $display("[TB] reset on the cycle a write is decided");
        number_of_flows = 2'd0;
        doReset();
        checkOutput("s7_error_cleared", error, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, i);
        idle(3);
        for (int i = 4; i < 8; i++) applyStimulus(1, 0, i);
        wc = writeCount;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        ev_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("s7_valid_dropped", sTx_c1.valid, 0);
        reset = 1'b0;
        idle(3);
        checkOutput("s7_no_write", writeCount - wc, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, i);
        idle(4);
        checkOutput("s7_count", writeCount - wc, 1);
        checkOutput("s7_seq", lastSeq, 0);
        checkOutput("s7_head", lastHead, 4);

        $display("[TB] randomized traffic");
        for (int seg = 0; seg < 4; seg++) begin
            number_of_flows = NFW'($urandom_range(0, 3));
            rx_queue_size   = QW'($urandom_range(3, 7));
            rx_bk_base_addr = t_ccip_clAddr'({$urandom(), $urandom()});
            start           = 1'b1;
            sRx_c1TxAlmFull = 1'b0;
            doReset();
            for (int i = 0; i < 600; i++) randomStep();
            start           = 1'b1;
            sRx_c1TxAlmFull = 1'b0;
            idle(TO + 10);
            checkOutput("drain_empty", expQ.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
